// File: rtl/regfile_multiport.sv
// Multiport register file with hardwired-zero r0, write-to-read bypass and per-register busy scoreboard.
// Latency: writes and scoreboard updates land at the next clk edge; reads are combinational.
// Backpressure: none; every write, clear and alloc is accepted in the cycle it is presented.
module regfile_multiport #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 1,
    parameter int ZERO_REG0 = 1,
    parameter int BYPASS    = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*AW-1:0]     waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_WR-1:0]        wclr,
    input  logic                     alloc_valid,
    input  logic [AW-1:0]            alloc_addr,
    input  logic [NUM_RD*AW-1:0]     raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    output logic [DEPTH-1:0]         busy_vec
);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic [AW-1:0]     wa  [NUM_WR];
    logic [DATA_W-1:0] wd  [NUM_WR];
    logic [NUM_WR-1:0] wen;
    logic              alloc_en;

    // A write to r0 is dropped here so storage, bypass and clear all see it as absent.
    for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
        assign wa[k]  = waddr[k*AW +: AW];
        assign wd[k]  = wdata[k*DATA_W +: DATA_W];
        assign wen[k] = we[k] && !(ZERO_REG0 != 0 && wa[k] == '0);
    end

    assign alloc_en = alloc_valid && !(ZERO_REG0 != 0 && alloc_addr == '0);

    // Alloc is applied after clears: a new producer supersedes the retiring one.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wen[k] && wclr[k]) begin
                busy_d[wa[k]] = 1'b0;
            end
        end
        if (alloc_en) begin
            busy_d[alloc_addr] = 1'b1;
        end
    end

    // Later ports overwrite earlier ones, so the highest index wins a conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wen[k]) begin
                    regs[wa[k]] <= wd[k];
                end
            end
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [AW-1:0]     ra;
        logic [DATA_W-1:0] val;
        logic              bsy;

        assign ra = raddr[r*AW +: AW];

        always_comb begin
            val = regs[ra];
            bsy = busy_q[ra];
            if (BYPASS != 0) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wen[k] && wa[k] == ra) begin
                        val = wd[k];
                        if (wclr[k]) begin
                            bsy = 1'b0;
                        end
                    end
                end
            end
            if (ZERO_REG0 != 0 && ra == '0) begin
                val = '0;
                bsy = 1'b0;
            end
        end

        assign rdata[r*DATA_W +: DATA_W] = val;
        assign rbusy[r]                  = bsy;
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: one bypassing and one non-bypassing instance share stimulus.
// Expected values are queued as stimulus is driven and popped when the outputs are sampled.
module tb_regfile_multiport;

    localparam int DW = 32;
    localparam int DP = 32;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int AW = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NW-1:0]    wclr;
    logic             alloc_valid;
    logic [AW-1:0]    alloc_addr;
    logic [NR*AW-1:0] raddr;

    logic [NR*DW-1:0] rdata_b, rdata_n;
    logic [NR-1:0]    rbusy_b, rbusy_n;
    logic [DP-1:0]    busy_b, busy_n;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    regfile_multiport #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR), .NUM_WR(NW),
                        .ZERO_REG0(1), .BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wclr(wclr),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .raddr(raddr),
        .rdata(rdata_b), .rbusy(rbusy_b), .busy_vec(busy_b)
    );

    regfile_multiport #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR), .NUM_WR(NW),
                        .ZERO_REG0(1), .BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wclr(wclr),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .raddr(raddr),
        .rdata(rdata_n), .rbusy(rbusy_n), .busy_vec(busy_n)
    );

    task automatic push(input string tag, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic pop_chk(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow observed=%h expected=<none>", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic idle();
        we          = '0;
        wclr        = '0;
        waddr       = '0;
        wdata       = '0;
        alloc_valid = 1'b0;
        alloc_addr  = '0;
    endtask

    task automatic wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic clr);
        we[port]             = 1'b1;
        wclr[port]           = clr;
        waddr[port*AW +: AW] = a;
        wdata[port*DW +: DW] = d;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    // Drive at posedge+1, sample at posedge+3, well clear of either edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        rd(5'd0, 5'd5);
        tick();
        reset = 1'b0;
        push("rst_busy_b", 64'h0);
        push("rst_busy_n", 64'h0);
        push("rst_rdata_b", 64'h0);
        push("rst_rbusy_b", 64'h0);
        settle();
        pop_chk(64'(busy_b));
        pop_chk(64'(busy_n));
        pop_chk(64'(rdata_b));
        pop_chk(64'(rbusy_b));

        // Populate r5 and r7-busy, then reset over an in-flight write.
        wr(0, 5'd5, 32'hDEADBEEF, 1'b0);
        alloc_valid = 1'b1;
        alloc_addr  = 5'd7;
        tick();
        idle();
        rd(5'd5, 5'd7);
        push("pre_rst_r5", 64'hDEADBEEF);
        push("pre_rst_busy", 64'h80);
        push("pre_rst_rbusy", 64'h2);
        settle();
        pop_chk(64'(rdata_n[31:0]));
        pop_chk(64'(busy_n));
        pop_chk(64'(rbusy_n));

        reset = 1'b1;
        wr(0, 5'd5, 32'h1234, 1'b0);
        alloc_valid = 1'b1;
        alloc_addr  = 5'd7;
        tick();
        reset = 1'b0;
        idle();
        rd(5'd5, 5'd7);
        push("mid_rst_r5_b", 64'h0);
        push("mid_rst_r5_n", 64'h0);
        push("mid_rst_busy_b", 64'h0);
        push("mid_rst_busy_n", 64'h0);
        settle();
        pop_chk(64'(rdata_b[31:0]));
        pop_chk(64'(rdata_n[31:0]));
        pop_chk(64'(busy_b));
        pop_chk(64'(busy_n));

        // Basic write then read on both ports.
        wr(0, 5'd3, 32'hA5A5A5A5, 1'b0);
        tick();
        idle();
        rd(5'd3, 5'd0);
        push("rw_r3_r0", {32'h0, 32'hA5A5A5A5});
        settle();
        pop_chk(64'(rdata_n));

        // r0 is hardwired: neither bypass nor storage may expose the write.
        wr(0, 5'd0, 32'hFFFFFFFF, 1'b0);
        rd(5'd0, 5'd0);
        push("r0_bypass", 64'h0);
        settle();
        pop_chk(64'(rdata_b));
        tick();
        idle();
        push("r0_stored", 64'h0);
        settle();
        pop_chk(64'(rdata_n));

        // Same-cycle write forwarding versus registered read.
        wr(0, 5'd9, 32'h55, 1'b0);
        rd(5'd9, 5'd3);
        push("byp_r9_b", 64'h55);
        push("byp_r9_n_old", 64'h0);
        settle();
        pop_chk(64'(rdata_b[31:0]));
        pop_chk(64'(rdata_n[31:0]));
        tick();
        idle();
        push("byp_r9_n_next", 64'h55);
        settle();
        pop_chk(64'(rdata_n[31:0]));

        // Two ports hit r4 in one cycle: port 1 wins both in bypass and storage.
        wr(0, 5'd4, 32'h11, 1'b0);
        wr(1, 5'd4, 32'h22, 1'b0);
        rd(5'd4, 5'd9);
        push("conf_byp", 64'h22);
        settle();
        pop_chk(64'(rdata_b[31:0]));
        tick();
        idle();
        push("conf_b", {32'h55, 32'h22});
        push("conf_n", {32'h55, 32'h22});
        settle();
        pop_chk(64'(rdata_b));
        pop_chk(64'(rdata_n));

        // Scoreboard set then clear via writeback.
        alloc_valid = 1'b1;
        alloc_addr  = 5'd6;
        tick();
        idle();
        rd(5'd6, 5'd0);
        push("sb_busy6", 64'h40);
        push("sb_rbusy_b", 64'h1);
        push("sb_rbusy_n", 64'h1);
        settle();
        pop_chk(64'(busy_b));
        pop_chk(64'(rbusy_b));
        pop_chk(64'(rbusy_n));

        wr(0, 5'd6, 32'h66, 1'b1);
        push("clr_rbusy_b", 64'h0);
        push("clr_rbusy_n", 64'h1);
        push("clr_busyvec_pre", 64'h40);
        settle();
        pop_chk(64'(rbusy_b));
        pop_chk(64'(rbusy_n));
        pop_chk(64'(busy_b));
        tick();
        idle();
        push("clr_busyvec_b", 64'h0);
        push("clr_busyvec_n", 64'h0);
        push("clr_r6", 64'h66);
        settle();
        pop_chk(64'(busy_b));
        pop_chk(64'(busy_n));
        pop_chk(64'(rdata_n[31:0]));

        // Alloc and clear collide on r8: set wins, data still lands.
        alloc_valid = 1'b1;
        alloc_addr  = 5'd8;
        wr(0, 5'd8, 32'h88, 1'b1);
        rd(5'd8, 5'd0);
        tick();
        idle();
        push("coll_busy", 64'h100);
        push("coll_rbusy_b", 64'h1);
        push("coll_r8", 64'h88);
        settle();
        pop_chk(64'(busy_b));
        pop_chk(64'(rbusy_b));
        pop_chk(64'(rdata_n[31:0]));

        // Alloc of r0 ignored; re-alloc of busy r8 keeps it busy.
        alloc_valid = 1'b1;
        alloc_addr  = 5'd0;
        tick();
        alloc_addr  = 5'd8;
        tick();
        idle();
        rd(5'd0, 5'd8);
        push("alloc0_busy_b", 64'h100);
        push("alloc0_busy_n", 64'h100);
        push("alloc0_rbusy", 64'h2);
        settle();
        pop_chk(64'(busy_b));
        pop_chk(64'(busy_n));
        pop_chk(64'(rbusy_b));

        if (sbq.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL sb_leftover observed=%0d expected=0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
